// File: rtl/uart_bus_bridge_pkg.sv
// Shared types and protocol constants for the UART-to-bus bridge.
package uart_bus_bridge_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StData,
      StBus,
      StRdWait,
      StResp,
      StRdata
   } bridgeState;

   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] RSP_ACK   = 8'h06;
   localparam logic [7:0] RSP_NAK   = 8'h15;

   localparam int unsigned TX_LEN_W = 3;

   function automatic logic [7:0] respByte(input logic err);
      return err ? RSP_NAK : RSP_ACK;
   endfunction

endpackage

// File: rtl/uart_bus_bridge_txseq.sv
// Serializes a 1..5 byte response (first byte in payload[39:32]) over the
// tx_valid/tx_done handshake and pulses done after the last byte completes.
module uart_bus_bridge_txseq
   import uart_bus_bridge_pkg::*;
(
   input  logic                clk,
   input  logic                nReset,
   input  logic                start,
   input  logic [TX_LEN_W-1:0] len,
   input  logic [39:0]         payload,
   output logic [7:0]          tx_data,
   output logic                tx_valid,
   input  logic                tx_done,
   output logic                done
);

   logic [39:0]         shiftReg;
   logic [TX_LEN_W-1:0] remaining;
   logic                active;

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         shiftReg  <= '0;
         remaining <= '0;
         active    <= 1'b0;
         tx_data   <= 8'h00;
         tx_valid  <= 1'b0;
         done      <= 1'b0;
      end else begin
         tx_valid <= 1'b0;
         done     <= 1'b0;
         if (!active) begin
            if (start) begin
               tx_data   <= payload[39:32];
               tx_valid  <= 1'b1;
               shiftReg  <= {payload[31:0], 8'h00};
               remaining <= len;
               active    <= 1'b1;
            end
         // A tx_done coincident with our own tx_valid belongs to nothing we sent.
         end else if (tx_done && !tx_valid) begin
            if (remaining == TX_LEN_W'(1)) begin
               active <= 1'b0;
               done   <= 1'b1;
            end else begin
               tx_data   <= shiftReg[39:32];
               tx_valid  <= 1'b1;
               shiftReg  <= {shiftReg[31:0], 8'h00};
               remaining <= remaining - TX_LEN_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/uart_bus_bridge.sv
// UART command frames ('R'/'W' + address [+ data]) to a single-beat bus access.
// Define UART_BUS_BRIDGE_TIMEOUT_EN to abort half-received frames after TIMEOUT_CYCLES idle cycles.
module uart_bus_bridge
   import uart_bus_bridge_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        nReset,
   input  logic [7:0]  rx_data,
   input  logic        rx_done,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_done,
   output logic        ren,
   output logic        wen,
   output logic [31:0] addr,
   output logic [31:0] wdata,
   output logic [3:0]  strobe,
   input  logic [31:0] rdata,
   input  logic        error,
   input  logic        request_stall,
   output logic        busy
);

   bridgeState          state;
   logic                cmdRead;
   logic [1:0]          byteCnt;
   logic                errQ;
   logic [31:0]         rdataQ;
   logic                txStart;
   logic [TX_LEN_W-1:0] txLen;
   logic [39:0]         txPayload;
   logic                txDone;

`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] ToLast = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] ToMax  = TW'(TIMEOUT_CYCLES);
   logic [TW-1:0] toCnt;
`endif

   assign busy = (state != StIdle);

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state     <= StIdle;
         cmdRead   <= 1'b0;
         byteCnt   <= 2'd0;
         errQ      <= 1'b0;
         rdataQ    <= '0;
         addr      <= '0;
         wdata     <= '0;
         strobe    <= 4'h0;
         ren       <= 1'b0;
         wen       <= 1'b0;
         txStart   <= 1'b0;
         txLen     <= '0;
         txPayload <= '0;
`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
         toCnt     <= '0;
`endif
      end else begin
         txStart <= 1'b0;
         unique case (state)
            StIdle: if (rx_done) begin
               if (rx_data == CMD_READ || rx_data == CMD_WRITE) begin
                  cmdRead <= (rx_data == CMD_READ);
                  byteCnt <= 2'd0;
                  state   <= StAddr;
               end else begin
                  cmdRead   <= 1'b0;
                  txStart   <= 1'b1;
                  txLen     <= TX_LEN_W'(1);
                  txPayload <= {RSP_NAK, 32'h0};
                  state     <= StResp;
               end
            end
            StAddr: if (rx_done) begin
               addr    <= {addr[23:0], rx_data};
               byteCnt <= byteCnt + 2'd1;
               if (byteCnt == 2'd3) begin
                  if (cmdRead) begin
                     ren    <= 1'b1;
                     strobe <= 4'hF;
                     state  <= StBus;
                  end else begin
                     state <= StData;
                  end
               end
            end
            StData: if (rx_done) begin
               wdata   <= {wdata[23:0], rx_data};
               byteCnt <= byteCnt + 2'd1;
               if (byteCnt == 2'd3) begin
                  wen    <= 1'b1;
                  strobe <= 4'hF;
                  state  <= StBus;
               end
            end
            StBus: if (!request_stall) begin
               ren    <= 1'b0;
               wen    <= 1'b0;
               strobe <= 4'h0;
               errQ   <= error;
               if (cmdRead) begin
                  state <= StRdWait;
               end else begin
                  txStart   <= 1'b1;
                  txLen     <= TX_LEN_W'(1);
                  txPayload <= {respByte(error), 32'h0};
                  state     <= StResp;
               end
            end
            StRdWait: begin
               rdataQ    <= rdata;
               txStart   <= 1'b1;
               txLen     <= TX_LEN_W'(1);
               txPayload <= {respByte(errQ), 32'h0};
               state     <= StResp;
            end
            StResp: if (txDone) begin
               if (cmdRead && !errQ) begin
                  txStart   <= 1'b1;
                  txLen     <= TX_LEN_W'(4);
                  txPayload <= {rdataQ, 8'h00};
                  state     <= StRdata;
               end else begin
                  state <= StIdle;
               end
            end
            StRdata: if (txDone) state <= StIdle;
            default: state <= StIdle;
         endcase
`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
         // Counts idle cycles inside a frame; overrides the case above on expiry.
         if ((state == StAddr || state == StData) && !rx_done) begin
            if (toCnt == ToLast) begin
               toCnt <= '0;
               state <= StIdle;
            end else if (toCnt != ToMax) begin
               toCnt <= toCnt + TW'(1);
            end
         end else begin
            toCnt <= '0;
         end
`endif
      end
   end

   uart_bus_bridge_txseq uTxSeq (
      .clk      (clk),
      .nReset   (nReset),
      .start    (txStart),
      .len      (txLen),
      .payload  (txPayload),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_done  (tx_done),
      .done     (txDone)
   );

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Randomized self-checking bench for uart_bus_bridge against a frame-level model.
module tb_uart_bus_bridge;

   logic        clk = 1'b0;
   logic        nReset = 1'b0;
   logic [7:0]  rx_data;
   logic        rx_done;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_done;
   logic        ren, wen;
   logic [31:0] addr, wdata, rdata;
   logic [3:0]  strobe;
   logic        error, request_stall, busy;

   always #5 clk = ~clk;

   uart_bus_bridge #(.TIMEOUT_CYCLES(20)) dut (
      .clk           (clk),
      .nReset        (nReset),
      .rx_data       (rx_data),
      .rx_done       (rx_done),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_done       (tx_done),
      .ren           (ren),
      .wen           (wen),
      .addr          (addr),
      .wdata         (wdata),
      .strobe        (strobe),
      .rdata         (rdata),
      .error         (error),
      .request_stall (request_stall),
      .busy          (busy)
   );

   typedef struct {
      bit          isRead;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          len;
   } busExp_t;

   int          checks = 0;
   int          errors = 0;
   busExp_t     expBus[$];
   logic [7:0]  expTx[$];
   logic [7:0]  txLog[$];
   int          stallCfg = 0;
   bit          errCfg = 0;
   logic [31:0] rdataCfg = '0;
   bit          txOutstanding = 0;
   bit          busActive = 0;
   busExp_t     curBus;
   int          busCycles = 0;
   logic [31:0] lastAddr, lastWdata;
   int          lastCycles = 0;
   bit          lastRead = 0;
   int          busCount = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Compare process: every transmitted byte and every bus cycle against the model.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!nReset) begin
            busActive     = 0;
            txOutstanding = 0;
            continue;
         end
         if (tx_valid) begin
            check("tx_no_overlap", 64'(txOutstanding), 64'd0);
            check("tx_expected", 64'(expTx.size() != 0), 64'd1);
            txLog.push_back(tx_data);
            if (expTx.size() != 0) check("tx_byte", 64'(tx_data), 64'(expTx.pop_front()));
            txOutstanding = 1;
         end else if (tx_done) begin
            txOutstanding = 0;
         end
         if (ren || wen) begin
            if (!busActive) begin
               check("bus_expected", 64'(expBus.size() != 0), 64'd1);
               if (expBus.size() != 0) begin
                  curBus    = expBus.pop_front();
                  busActive = 1;
                  busCycles = 0;
               end
            end
            if (busActive) begin
               busCycles++;
               check("bus_ren", 64'(ren), 64'(curBus.isRead));
               check("bus_wen", 64'(wen), 64'(!curBus.isRead));
               check("bus_addr", 64'(addr), 64'(curBus.addr));
               check("bus_strobe", 64'(strobe), 64'hF);
               if (!curBus.isRead) check("bus_wdata", 64'(wdata), 64'(curBus.wdata));
               if (!request_stall) begin
                  check("bus_cycles", 64'(busCycles), 64'(curBus.len));
                  lastAddr   = addr;
                  lastWdata  = wdata;
                  lastCycles = busCycles;
                  lastRead   = ren;
                  busActive  = 0;
                  busCount++;
               end
            end
         end
      end
   end

   // Transmitter model: random tx_done latency, occasional tx_done coincident with tx_valid.
   initial begin
      int txWait;
      txWait  = 0;
      tx_done = 1'b0;
      forever begin
         @(negedge clk);
         tx_done = 1'b0;
         if (!nReset) begin
            txWait = 0;
         end else if (txWait > 0) begin
            txWait--;
            if (txWait == 0) tx_done = 1'b1;
         end else if (tx_valid) begin
            txWait = $urandom_range(1, 4);
            if ($urandom_range(0, 3) == 0) tx_done = 1'b1;
         end
      end
   end

   // Bus target: stalls stallCfg cycles, error only valid at acceptance, rdata one cycle later.
   initial begin
      bit inAccess, acceptPending;
      int stallLeft;
      inAccess      = 0;
      acceptPending = 0;
      stallLeft     = 0;
      request_stall = 1'b0;
      error         = 1'b0;
      rdata         = '0;
      forever begin
         @(negedge clk);
         rdata = acceptPending ? rdataCfg : $urandom;
         acceptPending = 0;
         if (!nReset) begin
            inAccess = 0;
            continue;
         end
         if ((ren || wen) && !inAccess) begin
            inAccess  = 1;
            stallLeft = stallCfg;
         end
         if (inAccess) begin
            if (stallLeft > 0) begin
               request_stall = 1'b1;
               error         = $urandom_range(0, 1);
               stallLeft--;
            end else begin
               request_stall = 1'b0;
               error         = errCfg;
               acceptPending = 1;
               inAccess      = 0;
            end
         end else begin
            request_stall = $urandom_range(0, 1);
            error         = $urandom_range(0, 1);
         end
      end
   end

   task automatic sendByte(input logic [7:0] b, input bit gap);
      @(negedge clk);
      rx_data = b;
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
      rx_data = $urandom;
      if (gap) repeat ($urandom_range(0, 3)) @(negedge clk);
   endtask

   task automatic expectFrame(input bit isRead, input logic [31:0] a, input logic [31:0] d,
                              input int stall, input bit err, input logic [31:0] rd);
      busExp_t e;
      stallCfg = stall;
      errCfg   = err;
      rdataCfg = rd;
      e.isRead = isRead;
      e.addr   = a;
      e.wdata  = d;
      e.len    = stall + 1;
      expBus.push_back(e);
      expTx.push_back(err ? 8'h15 : 8'h06);
      if (isRead && !err) for (int i = 3; i >= 0; i--) expTx.push_back(rd[8*i +: 8]);
   endtask

   task automatic sendFrame(input bit isRead, input logic [31:0] a, input logic [31:0] d,
                            input bit inject);
      sendByte(isRead ? 8'h52 : 8'h57, 1);
      for (int i = 3; i >= 0; i--) sendByte(a[8*i +: 8], !(isRead && i == 0));
      if (!isRead) for (int i = 3; i >= 0; i--) sendByte(d[8*i +: 8], i != 0);
      if (inject) begin
         // Lands while the bridge is busy with the bus access; must be dropped.
         rx_data = 8'h52;
         rx_done = 1'b1;
         @(negedge clk);
         rx_done = 1'b0;
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      nReset = 1'b0;
      expTx.delete();
      expBus.delete();
      repeat (2) @(negedge clk);
      #1;
      check("rst_ren", 64'(ren), 64'd0);
      check("rst_wen", 64'(wen), 64'd0);
      check("rst_tx_valid", 64'(tx_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_addr", 64'(addr), 64'd0);
      check("rst_wdata", 64'(wdata), 64'd0);
      check("rst_tx_data", 64'(tx_data), 64'd0);
      check("rst_strobe", 64'(strobe), 64'd0);
      @(negedge clk);
      nReset = 1'b1;
   endtask

   task automatic waitDone(input string name);
      int n;
      n = 0;
      while ((expTx.size() != 0 || expBus.size() != 0 || busActive || txOutstanding) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check({name, "_complete"}, 64'(n < 2000), 64'd1);
      if (n >= 2000) doReset();
      repeat (4) @(negedge clk);
      #1;
      check({name, "_idle"}, 64'(busy), 64'd0);
   endtask

   task automatic checkLog(input string name, input int n, input logic [39:0] want);
      check({name, "_txcount"}, 64'(txLog.size()), 64'(n));
      for (int i = 0; i < n; i++)
         if (i < txLog.size()) check({name, "_txlit"}, 64'(txLog[i]), 64'(want[39-8*i -: 8]));
   endtask

   initial begin
      int          cnt0;
      logic [7:0]  b;
      logic [31:0] a, d, rd;
      bit          isRead, err;
      rx_data = 8'h00;
      rx_done = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("init_busy", 64'(busy), 64'd0);
      check("init_ren_wen", 64'({ren, wen}), 64'd0);
      check("init_tx_valid", 64'(tx_valid), 64'd0);
      check("init_addr", 64'(addr), 64'd0);
      @(negedge clk);
      nReset = 1'b1;

      // Write frame
      txLog.delete();
      expectFrame(0, 32'h0000100C, 32'h12345678, 0, 0, '0);
      sendFrame(0, 32'h0000100C, 32'h12345678, 0);
      waitDone("write");
      check("write_addr_lit", 64'(lastAddr), 64'h0000100C);
      check("write_wdata_lit", 64'(lastWdata), 64'h12345678);
      check("write_kind_lit", 64'(lastRead), 64'd0);
      check("write_cycles_lit", 64'(lastCycles), 64'd1);
      checkLog("write", 1, 40'h06_00000000);

      // Read frame
      txLog.delete();
      expectFrame(1, 32'h00000004, '0, 0, 0, 32'hDEADBEEF);
      sendFrame(1, 32'h00000004, '0, 0);
      waitDone("read");
      check("read_addr_lit", 64'(lastAddr), 64'h00000004);
      check("read_kind_lit", 64'(lastRead), 64'd1);
      checkLog("read", 5, 40'h06_DEADBEEF);

      // Stalled read
      txLog.delete();
      expectFrame(1, 32'h00000004, '0, 3, 0, 32'hDEADBEEF);
      sendFrame(1, 32'h00000004, '0, 0);
      waitDone("stall");
      check("stall_cycles_lit", 64'(lastCycles), 64'd4);
      checkLog("stall", 5, 40'h06_DEADBEEF);

      // Errors
      txLog.delete();
      expectFrame(0, 32'hA0000000, 32'h55AA55AA, 1, 1, '0);
      sendFrame(0, 32'hA0000000, 32'h55AA55AA, 0);
      waitDone("werr");
      checkLog("werr", 1, 40'h15_00000000);
      txLog.delete();
      expectFrame(1, 32'h00000010, '0, 0, 1, 32'hCAFEF00D);
      sendFrame(1, 32'h00000010, '0, 0);
      waitDone("rerr");
      checkLog("rerr", 1, 40'h15_00000000);

      // Bad command
      txLog.delete();
      cnt0 = busCount;
      expTx.push_back(8'h15);
      sendByte(8'h41, 0);
      waitDone("badcmd");
      check("badcmd_nobus", 64'(busCount), 64'(cnt0));
      checkLog("badcmd", 1, 40'h15_00000000);

      // Silence in the middle of a frame
      txLog.delete();
      cnt0 = busCount;
      sendByte(8'h57, 1);
      sendByte(8'h00, 0);
`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
      repeat (19) @(negedge clk);
      #1;
      check("timeout_before", 64'(busy), 64'd1);
      @(negedge clk);
      #1;
      check("timeout_after", 64'(busy), 64'd0);
      repeat (5) @(negedge clk);
      check("timeout_nobus", 64'(busCount), 64'(cnt0));
      check("timeout_notx", 64'(txLog.size()), 64'd0);
      expectFrame(1, 32'h00000004, '0, 0, 0, 32'h01020304);
      sendFrame(1, 32'h00000004, '0, 0);
      waitDone("post_timeout");
`else
      repeat (40) @(negedge clk);
      #1;
      check("notimeout_busy", 64'(busy), 64'd1);
      expectFrame(0, 32'h00112233, 32'h44556677, 0, 0, '0);
      for (int i = 2; i >= 0; i--) sendByte(8'(32'h00112233 >> (8*i)), 1);
      for (int i = 3; i >= 0; i--) sendByte(8'(32'h44556677 >> (8*i)), 1);
      waitDone("notimeout");
      check("notimeout_addr", 64'(lastAddr), 64'h00112233);
`endif

      // Reset mid-frame abandons it silently
      sendByte(8'h52, 1);
      sendByte(8'h00, 1);
      sendByte(8'h00, 0);
      doReset();
      repeat (5) @(negedge clk);
      expectFrame(0, 32'h00000020, 32'h0BADF00D, 1, 0, '0);
      sendFrame(0, 32'h00000020, 32'h0BADF00D, 0);
      waitDone("post_reset");

      // Random traffic
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 7) == 0) begin
            do b = 8'($urandom); while (b == 8'h52 || b == 8'h57);
            expTx.push_back(8'h15);
            sendByte(b, 0);
            waitDone("rand_bad");
         end else begin
            isRead = $urandom_range(0, 1);
            err    = ($urandom_range(0, 3) == 0);
            a      = $urandom;
            d      = $urandom;
            rd     = $urandom;
            expectFrame(isRead, a, d, $urandom_range(0, 3), err, rd);
            sendFrame(isRead, a, d, $urandom_range(0, 1));
            waitDone("rand_frame");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
